// File: rtl/stack_port.sv
// stack_port: push/pop sequencer owning an 8-entry register-file stack.
//   Runs on posedge Clk; the external pointer block updates SP/EMPTY on negedge.
//   Clk, Rst              clock, synchronous active-high reset
//   PUSH_REQ, POP_REQ     held requests (push wins when both are high)
//   DIN / DOUT            push data (latched at acceptance) / pop data (valid with ACK)
//   ACK, ERR, BUSY        completion pulse, overflow/underflow pulse, in-progress flag
//   SP, FULL, EMPTY       pointer state from the pointer block (FULL informational)
//   SP_INC, SP_DEC        one-cycle strobes to the pointer block
//   Optional macro STACK_PEEK_EN adds TOP / TOP_VALID combinational peek outputs.
module stack_port #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PUSH_REQ,
    input  logic             POP_REQ,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             ACK,
    output logic             ERR,
    output logic             BUSY,
    input  logic [2:0]       SP,
    input  logic             FULL,
    input  logic             EMPTY,
    output logic             SP_INC,
    output logic             SP_DEC
`ifdef STACK_PEEK_EN
   ,output logic [WIDTH-1:0] TOP,
    output logic             TOP_VALID
`endif
);
    typedef enum logic [2:0] {IDLE, PUSH, POP, SETTLE, DONE} state_t;
    state_t state, next;
    logic [WIDTH-1:0] mem [8];
    logic [WIDTH-1:0] data;
    logic err;
    logic ovf;
    logic [2:0] wr_idx;
    logic unused;
    assign unused = FULL;
    // Overflow is judged from the pointer itself, never from FULL.
    assign ovf = !EMPTY && SP == 3'd7;
    // An empty stack fills slot 0 while the pointer only clears EMPTY.
    assign wr_idx = EMPTY ? 3'd0 : SP + 3'd1;
    always_comb begin
        next = state;
        case (state)
            IDLE:     next = PUSH_REQ ? PUSH : POP_REQ ? POP : IDLE;
            PUSH:     next = SETTLE;
            POP:      next = SETTLE;
            SETTLE:   next = DONE;
            DONE:     next = IDLE;
            default:  next = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= next;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            SP_INC <= 1'b0;
            SP_DEC <= 1'b0;
            ACK    <= 1'b0;
            ERR    <= 1'b0;
            BUSY   <= 1'b0;
            DOUT   <= '0;
            err    <= 1'b0;
        end else begin
            BUSY   <= next != IDLE;
            ACK    <= next == DONE;
            ERR    <= next == DONE && err;
            // Strobes are registered so they live in SETTLE, where the pointer's negedge lands.
            SP_INC <= state == PUSH && !ovf;
            SP_DEC <= state == POP && !EMPTY;
            err    <= state == PUSH ? ovf : state == POP ? EMPTY : state == DONE ? 1'b0 : err;
            if (state == POP && !EMPTY) DOUT <= mem[SP];
        end
    end
    always_ff @(posedge Clk) begin
        if (!Rst && state == IDLE && PUSH_REQ) data <= DIN;
        if (!Rst && state == PUSH && !ovf) mem[wr_idx] <= data;
    end
`ifdef STACK_PEEK_EN
    assign TOP_VALID = !EMPTY;
    assign TOP = TOP_VALID ? mem[SP] : '0;
`endif
endmodule

// File: tb/tb_stack_port.sv
// tb_stack_port: directed self-checking bench for stack_port with a negedge pointer model.
module tb_stack_port;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       PUSH_REQ = 1'b0;
    logic       POP_REQ = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic [7:0] DOUT;
    logic       ACK, ERR, BUSY, SP_INC, SP_DEC;
    logic [2:0] SP = 3'd0;
    logic       EMPTY = 1'b1;
    logic       FULL;
`ifdef STACK_PEEK_EN
    logic [7:0] TOP;
    logic       TOP_VALID;
`endif
    assign FULL = !EMPTY && SP == 3'd7;

    stack_port #(.WIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .PUSH_REQ(PUSH_REQ), .POP_REQ(POP_REQ),
        .DIN(DIN), .DOUT(DOUT), .ACK(ACK), .ERR(ERR), .BUSY(BUSY),
        .SP(SP), .FULL(FULL), .EMPTY(EMPTY), .SP_INC(SP_INC), .SP_DEC(SP_DEC)
`ifdef STACK_PEEK_EN
       ,.TOP(TOP), .TOP_VALID(TOP_VALID)
`endif
    );

    always #5 Clk = ~Clk;

    // Pointer block model: updates on negedge, first push only clears EMPTY,
    // last pop only sets EMPTY.
    always @(negedge Clk) begin
        if (Rst) begin
            SP    <= 3'd0;
            EMPTY <= 1'b1;
        end else if (SP_INC) begin
            if (EMPTY) EMPTY <= 1'b0;
            else if (SP != 3'd7) SP <= SP + 3'd1;
        end else if (SP_DEC) begin
            if (SP == 3'd0) EMPTY <= 1'b1;
            else SP <= SP - 3'd1;
        end
    end

    int checks = 0;
    int errors = 0;
    int lat, incs, decs, busys, both;
    logic got_ack, got_err;
    logic [7:0] got_dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input string tag);
        lat = 0; incs = 0; decs = 0; busys = 0; both = 0; got_ack = 0; got_err = 0; got_dout = 0;
        while (!got_ack && lat < 12) begin
            @(negedge Clk); #1;
            lat++;
            incs += int'(SP_INC);
            decs += int'(SP_DEC);
            busys += int'(BUSY);
            both += int'(SP_INC && SP_DEC);
            if (ACK) begin
                got_ack = 1;
                got_err = ERR;
                got_dout = DOUT;
            end
        end
        check({tag, "_ack"}, 32'(got_ack), 1);
    endtask

    task automatic op(input logic push, input logic [7:0] d, input string tag, input logic exp_err);
        PUSH_REQ = push;
        POP_REQ = !push;
        DIN = d;
        wait_ack(tag);
        PUSH_REQ = 0;
        POP_REQ = 0;
        check({tag, "_lat"}, 32'(lat), 3);
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_inc"}, 32'(incs), 32'(push && !exp_err));
        check({tag, "_dec"}, 32'(decs), 32'(!push && !exp_err));
        check({tag, "_busy"}, 32'(busys), 3);
        check({tag, "_both"}, 32'(both), 0);
        @(negedge Clk); #1;
        check({tag, "_ack_width"}, 32'(ACK), 0);
    endtask

    initial begin
        int acks;
        repeat (3) @(negedge Clk);
        #1;
        check("rst_ack", 32'(ACK), 0);
        check("rst_err", 32'(ERR), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_inc", 32'(SP_INC), 0);
        check("rst_dec", 32'(SP_DEC), 0);
        check("rst_dout", 32'(DOUT), 0);
        Rst = 0;
        @(negedge Clk); #1;

        op(0, 8'h00, "pop_empty_rst", 1);
        check("pop_empty_rst_dout", 32'(got_dout), 8'h00);

        op(1, 8'hA5, "push_a5", 0);
        check("push_a5_sp", 32'(SP), 0);
        check("push_a5_empty", 32'(EMPTY), 0);
        op(0, 8'h00, "pop_a5", 0);
        check("pop_a5_dout", 32'(got_dout), 8'hA5);
        check("pop_a5_empty", 32'(EMPTY), 1);

        op(1, 8'h11, "push_11", 0);
        op(1, 8'h22, "push_22", 0);
        op(1, 8'h33, "push_33", 0);
        check("three_sp", 32'(SP), 2);
        op(0, 8'h00, "pop_33", 0);
        check("pop_33_dout", 32'(got_dout), 8'h33);
        op(0, 8'h00, "pop_22", 0);
        check("pop_22_dout", 32'(got_dout), 8'h22);
        op(0, 8'h00, "pop_11", 0);
        check("pop_11_dout", 32'(got_dout), 8'h11);
        check("pop_11_sp", 32'(SP), 0);
        check("pop_11_empty", 32'(EMPTY), 1);

        for (int i = 0; i < 8; i++) op(1, 8'(i), "fill", 0);
        check("fill_sp", 32'(SP), 7);
        op(1, 8'hFF, "overflow", 1);
        check("overflow_sp", 32'(SP), 7);
        op(0, 8'h00, "pop_07", 0);
        check("pop_07_dout", 32'(got_dout), 8'h07);
        for (int i = 6; i >= 0; i--) begin
            op(0, 8'h00, "drain", 0);
            check("drain_dout", 32'(got_dout), 32'(i));
        end
        check("drain_empty", 32'(EMPTY), 1);

        op(1, 8'h5A, "push_5a", 0);
        op(0, 8'h00, "pop_5a", 0);
        check("pop_5a_dout", 32'(got_dout), 8'h5A);
        op(0, 8'h00, "pop_empty", 1);
        check("pop_empty_dout_hold", 32'(got_dout), 8'h5A);

        PUSH_REQ = 1;
        POP_REQ = 1;
        DIN = 8'h77;
        wait_ack("dual_push");
        PUSH_REQ = 0;
        check("dual_push_lat", 32'(lat), 3);
        check("dual_push_inc", 32'(incs), 1);
        check("dual_push_dec", 32'(decs), 0);
        check("dual_push_err", 32'(got_err), 0);
        wait_ack("dual_pop");
        POP_REQ = 0;
        check("dual_pop_lat", 32'(lat), 4);
        check("dual_pop_dout", 32'(got_dout), 8'h77);
        check("dual_pop_dec", 32'(decs), 1);
        check("dual_pop_inc", 32'(incs), 0);
        check("dual_pop_err", 32'(got_err), 0);
        @(negedge Clk); #1;
        check("dual_empty", 32'(EMPTY), 1);

`ifdef STACK_PEEK_EN
        check("peek_empty_valid", 32'(TOP_VALID), 0);
        check("peek_empty_top", 32'(TOP), 0);
        op(1, 8'h10, "peek_push_10", 0);
        op(1, 8'h20, "peek_push_20", 0);
        check("peek_top", 32'(TOP), 8'h20);
        check("peek_valid", 32'(TOP_VALID), 1);
        op(0, 8'h00, "peek_pop1", 0);
        check("peek_top_after1", 32'(TOP), 8'h10);
        op(0, 8'h00, "peek_pop2", 0);
        check("peek_valid_after2", 32'(TOP_VALID), 0);
        check("peek_top_after2", 32'(TOP), 0);
`endif

        PUSH_REQ = 1;
        DIN = 8'h99;
        @(negedge Clk); #1;
        PUSH_REQ = 0;
        check("settle_busy", 32'(BUSY), 1);
        @(negedge Clk); #1;
        check("settle_inc", 32'(SP_INC), 1);
        Rst = 1;
        @(posedge Clk); #1;
        check("abort_ack", 32'(ACK), 0);
        check("abort_err", 32'(ERR), 0);
        check("abort_busy", 32'(BUSY), 0);
        check("abort_inc", 32'(SP_INC), 0);
        check("abort_dec", 32'(SP_DEC), 0);
        check("abort_dout", 32'(DOUT), 0);
        @(negedge Clk); #1;
        Rst = 0;
        acks = 0;
        repeat (6) begin
            @(negedge Clk); #1;
            acks += int'(ACK);
        end
        check("abort_no_ack", 32'(acks), 0);
        check("abort_empty", 32'(EMPTY), 1);

        op(1, 8'h42, "recover_push", 0);
        op(0, 8'h00, "recover_pop", 0);
        check("recover_dout", 32'(got_dout), 8'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
